// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel multiplexer / demultiplexer pair.
// Slot encoding matches the multiplexer select lines {sel1, sel2}.
package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;

    function automatic int unsigned frame_len(input int unsigned w);
        return 4 * w;
    endfunction

endpackage

// File: rtl/tdm_frame_counter.sv
// Frame position counter: slot number plus bit offset within the slot.
// Offset 0 is the slot MSB, so pos = slot * W + offset.
module tdm_frame_counter
    import tdm_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       inc,
    output logic [1:0] slot,
    output logic       pos_zero,
    output logic       last
);

    localparam logic [W-1:0] CntMax  = W'(W - 1);
    localparam int           LastPos = int'(frame_len(W)) - 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic [1:0]   slot_q, slot_d;

    always_comb begin
        cnt_d  = cnt_q;
        slot_d = slot_q;
        if (clr) begin
            cnt_d  = '0;
            slot_d = SLOT_A;
        end else if (load) begin
            // Position 1: second bit of slot a, or slot b when slots are one bit wide.
            if (W == 1) begin
                cnt_d  = '0;
                slot_d = SLOT_B;
            end else begin
                cnt_d  = W'(1);
                slot_d = SLOT_A;
            end
        end else if (inc) begin
            if (cnt_q == CntMax) begin
                cnt_d  = '0;
                slot_d = slot_q + 2'd1;
            end else begin
                cnt_d  = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            slot_q <= SLOT_A;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

    assign slot     = slot_q;
    assign pos_zero = (slot_q == SLOT_A) && (cnt_q == '0);
    assign last     = (int'(slot_q) * int'(W) + int'(cnt_q)) == LastPos;

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: locks to the frame-sync marker and presents
// each complete frame's slot values in parallel.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    input  logic         sync,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    tdm_state_e   state_q, state_d;
    logic [W-1:0] sr_q [4];
    logic [W-1:0] sr_d [4];
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic [W-1:0] a_d, b_d, c_d, d_d;
    logic         fv_q, fv_d;
    logic         err_q, err_d;

    logic         cnt_clr, cnt_load, cnt_inc;
    logic [1:0]   slot;
    logic         pos_zero, last;

    tdm_frame_counter #(
        .W (W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .slot     (slot),
        .pos_zero (pos_zero),
        .last     (last)
    );

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        sr_d         = '{default: '0};
                        sr_d[SLOT_A] = W'(din);
                        state_d      = LOCKED;
                        cnt_load     = 1'b1;
                    end
                end
                LOCKED: begin
                    if (pos_zero && !sync) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        cnt_clr = 1'b1;
                    end else if (sync) begin
                        // Frame start, normal or early: restart slot a from this bit.
                        err_d        = !pos_zero;
                        sr_d         = '{default: '0};
                        sr_d[SLOT_A] = W'(din);
                        cnt_load     = 1'b1;
                    end else begin
                        sr_d[slot] = W'({sr_q[slot], din});
                        cnt_inc    = 1'b1;
                        if (last) begin
                            a_d  = sr_d[SLOT_A];
                            b_d  = sr_d[SLOT_B];
                            c_d  = sr_d[SLOT_C];
                            d_d  = sr_d[SLOT_D];
                            fv_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sr_q    <= '{default: '0};
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign d           = d_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign locked      = (state_q == LOCKED);

endmodule
